// File: rtl/sdram_resp_module.sv
// rtl/sdram_resp_module.sv - single-word-burst SDRAM device responder for controller loopback
// Define SDRAM_RESP_CHECK_EN to compile in protocol error detection (Err_Sig/Err_Code, tRCD).
module sdram_resp_module #(
  parameter int ROW_BITS = 2,
  parameter int CL       = 2,
  parameter int TRCD     = 2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [4:0]  SDRAM_CMD,
  input  logic [13:0] SDRAM_BA,
  inout  wire  [15:0] SDRAM_DATA,
  input  logic        SDRAM_LDQM,
  input  logic        SDRAM_UDQM,
  output logic [11:0] Mode_Reg,
  output logic [15:0] AR_Count,
  output logic        Err_Sig,
  output logic [2:0]  Err_Code
);

  localparam int AW    = 2 + ROW_BITS + 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {B_IDLE, B_ACTIVE} bank_state_t;

  bank_state_t         bank_st  [4];
  logic [ROW_BITS-1:0] bank_row [4];
  logic [15:0]         mem      [DEPTH];
  logic [15:0]         rd_data  [CL];
  logic [CL-1:0]       rd_vld;

  logic          cmd_en;
  logic          is_act, is_rd, is_wr, is_pr, is_ar, is_lmr;
  logic [1:0]    bank;
  logic          a10;
  logic          bank_act, any_act, trcd_ok;
  logic          rw_ok, rd_ok, wr_ok;
  logic [AW-1:0] idx;

  assign cmd_en = SDRAM_CMD[4] & ~SDRAM_CMD[3];
  assign is_act = cmd_en && (SDRAM_CMD[2:0] == 3'b011);
  assign is_rd  = cmd_en && (SDRAM_CMD[2:0] == 3'b101);
  assign is_wr  = cmd_en && (SDRAM_CMD[2:0] == 3'b100);
  assign is_pr  = cmd_en && (SDRAM_CMD[2:0] == 3'b010);
  assign is_ar  = cmd_en && (SDRAM_CMD[2:0] == 3'b001);
  assign is_lmr = cmd_en && (SDRAM_CMD[2:0] == 3'b000);

  assign bank     = SDRAM_BA[13:12];
  assign a10      = SDRAM_BA[10];
  assign bank_act = (bank_st[bank] == B_ACTIVE);
  assign any_act  = (bank_st[0] == B_ACTIVE) || (bank_st[1] == B_ACTIVE) ||
                    (bank_st[2] == B_ACTIVE) || (bank_st[3] == B_ACTIVE);
  assign idx      = {bank, bank_row[bank], SDRAM_BA[7:0]};

  assign rw_ok = (is_rd || is_wr) && bank_act && trcd_ok;
  assign rd_ok = rw_ok && is_rd;
  assign wr_ok = rw_ok && is_wr;

  // Only the last pipeline stage owns the bus; everything else leaves it floating.
  assign SDRAM_DATA = rd_vld[CL-1] ? rd_data[CL-1] : 16'hzzzz;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int b = 0; b < 4; b++) begin
        bank_st[b]  <= B_IDLE;
        bank_row[b] <= '0;
      end
      for (int i = 0; i < CL; i++) rd_data[i] <= '0;
      rd_vld   <= '0;
      Mode_Reg <= '0;
      AR_Count <= '0;
    end else begin
      rd_vld <= {rd_vld[CL-2:0], 1'b0};
      for (int i = 1; i < CL; i++) rd_data[i] <= rd_data[i-1];

      if (is_act && !bank_act) begin
        bank_st[bank]  <= B_ACTIVE;
        bank_row[bank] <= SDRAM_BA[ROW_BITS-1:0];
      end
      if (is_pr) begin
        for (int b = 0; b < 4; b++)
          if (a10 || (bank == 2'(b))) bank_st[b] <= B_IDLE;
      end
      if (rw_ok && a10) bank_st[bank] <= B_IDLE;

      // A fully masked read still occupies its slot but never drives the bus.
      if (rd_ok) begin
        rd_vld[0]  <= ~(SDRAM_LDQM & SDRAM_UDQM);
        rd_data[0] <= mem[idx];
      end
      if (is_ar && !any_act) AR_Count <= AR_Count + 16'd1;
      if (is_lmr) Mode_Reg <= SDRAM_BA[11:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTn && wr_ok) begin
      if (!SDRAM_LDQM) mem[idx][7:0]  <= SDRAM_DATA[7:0];
      if (!SDRAM_UDQM) mem[idx][15:8] <= SDRAM_DATA[15:8];
    end
  end

`ifdef SDRAM_RESP_CHECK_EN
  localparam int TW = (TRCD > 1) ? $clog2(TRCD) : 1;

  logic [TW-1:0] trcd_cnt [4];
  logic [2:0]    err_now;

  assign trcd_ok = (trcd_cnt[bank] == '0);

  // One-word reads each land in their own slot, so the overlap code (5) cannot arise.
  always_comb begin
    err_now = 3'd0;
    if (is_act && bank_act)                    err_now = 3'd1;
    else if ((is_rd || is_wr) && !bank_act)    err_now = 3'd2;
    else if (is_ar && any_act)                 err_now = 3'd3;
    else if ((is_rd || is_wr) && !trcd_ok)     err_now = 3'd4;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int b = 0; b < 4; b++) trcd_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (trcd_cnt[b] != '0) trcd_cnt[b] <= trcd_cnt[b] - 1'b1;
      if (is_act && !bank_act) trcd_cnt[bank] <= TW'(TRCD - 1);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Err_Sig  <= 1'b0;
      Err_Code <= 3'd0;
    end else if (!Err_Sig && (err_now != 3'd0)) begin
      Err_Sig  <= 1'b1;
      Err_Code <= err_now;
    end
  end
`else
  assign trcd_ok  = 1'b1;
  assign Err_Sig  = 1'b0;
  assign Err_Code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_resp_module.sv
// tb/tb_sdram_resp_module.sv - scoreboard bench for sdram_resp_module against a behavioural SDRAM model
`timescale 1ns/1ps
module tb_sdram_resp_module;

  localparam int ROW_BITS = 2;
  localparam int CL       = 2;
  localparam int TRCD     = 2;
`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  localparam logic [4:0] C_NOP = 5'b10111;
  localparam logic [4:0] C_ACT = 5'b10011;
  localparam logic [4:0] C_RD  = 5'b10101;
  localparam logic [4:0] C_WR  = 5'b10100;
  localparam logic [4:0] C_PR  = 5'b10010;
  localparam logic [4:0] C_AR  = 5'b10001;
  localparam logic [4:0] C_LMR = 5'b10000;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [4:0]  cmd;
  logic [13:0] ba;
  logic        ldqm, udqm;
  logic        tb_drv;
  logic [15:0] tb_dq;
  wire  [15:0] dq;
  logic [11:0] Mode_Reg;
  logic [15:0] AR_Count;
  logic        Err_Sig;
  logic [2:0]  Err_Code;

  assign dq = tb_drv ? tb_dq : 16'hzzzz;

  sdram_resp_module #(.ROW_BITS(ROW_BITS), .CL(CL), .TRCD(TRCD)) dut (
    .CLK(CLK), .RSTn(RSTn), .SDRAM_CMD(cmd), .SDRAM_BA(ba), .SDRAM_DATA(dq),
    .SDRAM_LDQM(ldqm), .SDRAM_UDQM(udqm), .Mode_Reg(Mode_Reg), .AR_Count(AR_Count),
    .Err_Sig(Err_Sig), .Err_Code(Err_Code)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Behavioural model: bank table, word array with per-byte "written" flags, counters.
  bit          m_open [4];
  int          m_row  [4];
  int          m_act  [4];
  logic [15:0] m_mem  [4096];
  bit   [1:0]  m_known[4096];
  logic [15:0] m_ar;
  logic [11:0] m_mode;
  bit          m_err;
  logic [2:0]  m_code;

  typedef struct { int due; logic [15:0] data; bit dc; } exp_t;
  exp_t exp_q[$];

  function automatic bit bus_idle(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 4; b++) m_open[b] = 1'b0;
    m_ar = '0; m_mode = '0; m_err = 1'b0; m_code = '0;
  endtask

  task automatic model_cmd(input logic [4:0] c, input logic [13:0] a, input logic lm,
                           input logic um, input logic [15:0] wd, input int k);
    int b, e, idx;
    if (!(c[4] == 1'b1 && c[3] == 1'b0)) return;
    b = int'(a[13:12]);
    e = 0;
    case (c[2:0])
      3'b011: if (m_open[b]) e = 1;
              else begin m_open[b] = 1'b1; m_row[b] = int'(a[11:0]); m_act[b] = k; end
      3'b101, 3'b100: begin
        if (!m_open[b]) e = 2;
        else if (CHECK && (k - m_act[b] < TRCD)) e = 4;
        else begin
          idx = (b * (1 << ROW_BITS) + m_row[b] % (1 << ROW_BITS)) * 256 + int'(a[7:0]);
          if (c[0] == 1'b0) begin
            if (!lm) begin m_mem[idx][7:0]  = wd[7:0];  m_known[idx][0] = 1'b1; end
            if (!um) begin m_mem[idx][15:8] = wd[15:8]; m_known[idx][1] = 1'b1; end
          end else if (!(lm && um)) begin
            exp_q.push_back('{due: k + CL - 1, data: m_mem[idx], dc: (m_known[idx] != 2'b11)});
          end
          if (a[10]) m_open[b] = 1'b0;
        end
      end
      3'b010: begin
        if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        else m_open[b] = 1'b0;
      end
      3'b001: if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) e = 3;
              else m_ar = m_ar + 16'd1;
      3'b000: m_mode = a[11:0];
      default: ;
    endcase
    if (CHECK && e != 0 && !m_err) begin m_err = 1'b1; m_code = 3'(e); end
  endtask

  task automatic check_regs();
    chk("mode_reg", {4'h0, Mode_Reg}, {4'h0, m_mode});
    chk("ar_count", AR_Count, m_ar);
    chk("err_sig",  {15'h0, Err_Sig}, {15'h0, m_err});
    chk("err_code", {13'h0, Err_Code}, {13'h0, m_code});
  endtask

  task automatic issue(input logic [4:0] c, input logic [13:0] a, input logic lm,
                       input logic um, input logic [15:0] wd);
    cmd = c; ba = a; ldqm = lm; udqm = um; tb_dq = wd; tb_drv = (c == C_WR);
    @(posedge CLK);
    #1;
    model_cmd(c, a, lm, um, wd, cyc);
    cmd = C_NOP; tb_drv = 1'b0;
    check_regs();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) issue(C_NOP, 14'h0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic do_reset();
    cmd = C_NOP; tb_drv = 1'b0; RSTn = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    check_regs();
  endtask

  function automatic bit wr_collides();
    foreach (exp_q[i]) if (exp_q[i].due == cyc) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL rd_slot_missed: due %0d now %0d", e.due, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (!e.dc) chk("rd_data", dq, e.data);
      end else if (!tb_drv) begin
        checks++;
        if (!bus_idle(dq)) begin
          errors++;
          $display("FAIL bus_idle: got %h expected z (cycle %0d)", dq, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  rb;
    logic [11:0] rrow;
    logic [7:0]  rcol;
    logic        ra10, rl, ru;
    logic [15:0] rwd;
    int          r;

    RSTn = 1'b0; cmd = C_NOP; ba = '0; ldqm = 1'b0; udqm = 1'b0; tb_drv = 1'b0; tb_dq = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RSTn = 1'b1;
    mon_en = 1'b1;
    check_regs();

    issue(C_LMR, 14'h0020, 1'b0, 1'b0, 16'h0);
    chk("lmr_value", {4'h0, Mode_Reg}, 16'h0020);
    nops(2);

    // Write with auto-precharge, reopen on the next edge, read back.
    issue(C_ACT, {2'd1, 12'd3}, 1'b0, 1'b0, 16'h0);
    nops(2);
    issue(C_WR,  {2'd1, 12'h412}, 1'b0, 1'b0, 16'hA55A);
    issue(C_ACT, {2'd1, 12'd3}, 1'b0, 1'b0, 16'h0);
    nops(1);
    issue(C_RD,  {2'd1, 12'h012}, 1'b0, 1'b0, 16'h0);
    nops(3);

    // Byte mask: only the upper byte of the second write lands.
    issue(C_WR, {2'd1, 12'h020}, 1'b0, 1'b0, 16'hFFFF);
    issue(C_WR, {2'd1, 12'h020}, 1'b1, 1'b0, 16'h0000);
    issue(C_RD, {2'd1, 12'h020}, 1'b0, 1'b0, 16'h0);
    issue(C_RD, {2'd1, 12'h012}, 1'b1, 1'b0, 16'h0);
    issue(C_RD, {2'd1, 12'h012}, 1'b1, 1'b1, 16'h0);
    nops(3);
    issue(C_PR, 14'h0400, 1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 3; i++) begin
      issue(C_AR, 14'h0, 1'b0, 1'b0, 16'h0);
      nops(2);
    end
    chk("ar_count_3", AR_Count, 16'd3);
    issue(C_ACT, {2'd0, 12'd1}, 1'b0, 1'b0, 16'h0);
    issue(C_AR, 14'h0, 1'b0, 1'b0, 16'h0);
    chk("ar_blocked", AR_Count, 16'd3);
    chk("err_code_ar", {13'h0, Err_Code}, CHECK ? 16'd3 : 16'd0);

    do_reset();
    issue(C_RD, {2'd2, 12'h005}, 1'b0, 1'b0, 16'h0);
    nops(3);
    chk("err_code_idle", {13'h0, Err_Code}, CHECK ? 16'd2 : 16'd0);
    issue(C_ACT, {2'd0, 12'd0}, 1'b0, 1'b0, 16'h0);
    issue(C_ACT, {2'd0, 12'd0}, 1'b0, 1'b0, 16'h0);
    chk("err_code_kept", {13'h0, Err_Code}, CHECK ? 16'd2 : 16'd0);

    // Early RD/WR after ACT: blocked with checking, executed without.
    do_reset();
    issue(C_ACT, {2'd2, 12'd1}, 1'b0, 1'b0, 16'h0);
    issue(C_WR,  {2'd2, 12'h005}, 1'b0, 1'b0, 16'h1234);
    issue(C_WR,  {2'd2, 12'h005}, 1'b0, 1'b0, 16'h4321);
    issue(C_RD,  {2'd2, 12'h005}, 1'b0, 1'b0, 16'h0);
    nops(3);
    chk("err_code_trcd", {13'h0, Err_Code}, CHECK ? 16'd4 : 16'd0);

    // Reset while a read is on the bus.
    do_reset();
    issue(C_ACT, {2'd1, 12'd3}, 1'b0, 1'b0, 16'h0);
    nops(1);
    issue(C_RD, {2'd1, 12'h012}, 1'b0, 1'b0, 16'h0);
    cmd = C_NOP;
    @(posedge CLK);
    #1;
    chk("rd_before_rst", dq, 16'hA55A);
    RSTn = 1'b0;
    #1;
    checks++;
    if (!bus_idle(dq)) begin
      errors++;
      $display("FAIL rst_release: got %h expected z", dq);
    end
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    check_regs();
    issue(C_RD, {2'd1, 12'h012}, 1'b0, 1'b0, 16'h0);
    nops(3);
    issue(C_ACT, {2'd1, 12'd3}, 1'b0, 1'b0, 16'h0);
    nops(1);
    issue(C_RD, {2'd1, 12'h012}, 1'b0, 1'b0, 16'h0);
    nops(3);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      r    = int'($urandom_range(0, 99));
      rb   = 2'($urandom_range(0, 3));
      rrow = 12'($urandom_range(0, 4095));
      rcol = 8'($urandom_range(0, 15));
      ra10 = ($urandom_range(0, 3) == 0);
      rl   = 1'($urandom_range(0, 1));
      ru   = 1'($urandom_range(0, 1));
      rwd  = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
      if (r < 20)      issue(C_ACT, {rb, rrow}, 1'b0, 1'b0, 16'h0);
      else if (r < 45) issue(C_RD, {rb, 1'b0, ra10, 2'b00, rcol}, rl, ru, 16'h0);
      else if (r < 65) begin
        if (wr_collides()) issue(C_NOP, 14'h0, 1'b0, 1'b0, 16'h0);
        else issue(C_WR, {rb, 1'b0, ra10, 2'b00, rcol}, rl, ru, rwd);
      end
      else if (r < 78) issue(C_PR, {rb, 1'b0, ra10, 10'h0}, 1'b0, 1'b0, 16'h0);
      else if (r < 82) issue(C_AR, 14'h0, 1'b0, 1'b0, 16'h0);
      else if (r < 85) issue(C_LMR, {rb, rrow}, 1'b0, 1'b0, 16'h0);
      else if (r < 92) issue({2'b10, 3'($urandom_range(6, 7))}, {rb, rrow}, 1'b0, 1'b0, 16'h0);
      else if (r < 96) issue({2'b11, 3'($urandom_range(0, 7))}, {rb, rrow}, rl, ru, 16'h0);
      else             issue({2'b00, 3'($urandom_range(0, 7))}, {rb, rrow}, rl, ru, 16'h0);
    end
    nops(CL + 2);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
